frame_scheduler: RTL and testbench
==================================

Name: frame_scheduler

Overview:
- Sequences the per-frame game-logic tasks (player move, alien march, bullet update, collision check, etc.) inside vertical blanking.
- Triggered by the rising edge of the VGA timing generator's vsync.
- Issues each enabled task a one-cycle start pulse, then waits for that task's done handshake before moving to the next.
- Reports timeouts, frame overruns and a frame counter for the rest of the design.

Parameters:
- N_TASKS, 4: number of sequenced tasks. Range 1..16.
- TIMEOUT_CYCLES, 4096: maximum cycles spent waiting on one task's done signal. Must be >= 2.
- FC_WIDTH, 16: width of frame_count.

Ports:
- clk  input  1  pixel-domain clock, same clock as the VGA timing generator.
- clear_n  input  1  asynchronous, active-low reset.
- vsync  input  1  vertical sync, active-high, synchronous to clk.
- enable  input  1  when 0, vsync edges are ignored and no overrun is flagged.
- task_mask  input  N_TASKS  bit i = 1 means task i is run this frame. Sampled at each ISSUE.
- task_done  input  N_TASKS  bit i pulse or level means task i has completed.
- clear_err  input  1  one-cycle pulse that clears the sticky error flags.
- task_start  output  N_TASKS  one-hot, one-cycle start pulse.
- busy  output  1  high while a frame sequence is in progress.
- frame_count  output  FC_WIDTH  number of completed sequences; wraps.
- timeout_err  output  N_TASKS  sticky; bit i = 1 means task i timed out.
- overrun  output  1  sticky; a vsync edge arrived while busy.

Behaviour:
- Reset (clear_n = 0, asynchronous):
  - state = IDLE, idx = 0, timer = 0, vsync_d = 0.
  - All outputs are 0.
  - After reset release, nothing starts until a new vsync rising edge is seen.
- Edge detect: edge = vsync & ~vsync_d, with vsync_d registered every cycle.
- FSM states: IDLE, ISSUE, WAIT, FINISH. busy = (state != IDLE).
- IDLE:
  - On edge with enable = 1: idx <= 0, go to ISSUE.
  - Latency: task_start[0] is high in the cycle immediately after the clock edge that samples vsync rising.
- ISSUE (lasts exactly one cycle):
  - task_start[idx] = task_mask[idx]. All other start bits are 0.
  - If task_mask[idx] = 1: timer <= 0, go to WAIT.
  - If task_mask[idx] = 0 (task skipped, costs one cycle): advance.
- WAIT:
  - task_done[idx] is ignored during the ISSUE cycle and only honoured in WAIT.
  - If task_done[idx] = 1: advance.
  - Else if timer == TIMEOUT_CYCLES-1: set timeout_err[idx], then advance.
  - Else: timer <= timer + 1.
  - WAIT therefore lasts at most TIMEOUT_CYCLES cycles.
  - done arriving in the final cycle wins; no error is set.
  - Other task_done bits are ignored.
- Advance:
  - If idx == N_TASKS-1: go to FINISH.
  - Else: idx <= idx + 1, go to ISSUE.
- FINISH (lasts one cycle): frame_count <= frame_count + 1, wrapping from all-ones to 0; go to IDLE.
- All-masked frame: completes in N_TASKS+1 cycles with no start pulses, and frame_count still increments.
- Overrun:
  - An edge arriving in ISSUE, WAIT or FINISH sets overrun.
  - That edge is discarded: no restart and no queueing.
- enable deasserted mid-sequence: the current sequence still completes.
- clear_err:
  - Clears timeout_err and overrun on the next edge.
  - If a set and a clear happen in the same cycle, set wins.
- Width rule: timer width is $clog2(TIMEOUT_CYCLES).

Optional Feature:
- Macro: FRAME_SCHED_DIVIDER_EN.
- When defined:
  - Adds input frame_div [3:0] and an internal 4-bit edge counter (reset 0).
  - An edge seen in IDLE with enable = 1 launches a sequence only when edge_cnt == frame_div. The counter then resets to 0.
  - Otherwise the counter increments and no sequence launches.
  - Result: the game logic runs every (frame_div+1)th frame.
  - Edges seen while busy count as overrun and do not advance the counter.
- When not defined: no port is added, and every qualifying edge launches a sequence.

Test Plan:
- Reset: hold clear_n = 0 with vsync toggling -> every output is 0. Release clear_n with vsync already high -> no start pulse until vsync falls and then rises again.
- Basic sequence (N_TASKS=4, TIMEOUT_CYCLES=16, task_mask=4'b1111):
  - vsync rise is sampled at cycle 10.
  - Each task_done[i] is driven high 3 cycles after its start pulse.
  - Expected: task_start pulses at cycles 11, 15, 19, 23; FINISH at cycle 27; busy low from cycle 28; frame_count = 1.
- Masking (task_mask=4'b0101, done 3 cycles after start):
  - Expected: only task_start[0] (cycle 11) and task_start[2] (cycle 16) pulse.
  - The skipped tasks take 1 cycle each.
  - frame_count increments once.
- Timeout: task_done[1] held at 0.
  - Expected: WAIT lasts 16 cycles, then timeout_err = 4'b0010.
  - task_start[2] is high on the following cycle.
  - A clear_err pulse afterwards returns timeout_err to 0.
- Overrun: second vsync rise during task 1's WAIT.
  - Expected: overrun = 1, the sequence is not restarted, and frame_count increments by exactly 1.
  - Drive clear_err and a new task timeout in the same cycle -> timeout bit is set (set wins).
- Async reset during WAIT, then divider:
  - Drop clear_n mid-WAIT -> busy and task_start go to 0 immediately.
  - With FRAME_SCHED_DIVIDER_EN and frame_div=2 over 9 vsync edges -> sequences launch on edges 3, 6 and 9 only.

Source files
------------

// File: rtl/frame_scheduler.sv
// frame_scheduler: runs the enabled per-frame game-logic tasks one after
// another on each vsync rising edge, with per-task timeout, overrun detection
// and a completed-frame counter.
// Optional feature: define FRAME_SCHED_DIVIDER_EN to add the frame_div input,
// which launches a sequence only on every (frame_div+1)th qualifying edge.
module frame_scheduler #(
    parameter int N_TASKS        = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int FC_WIDTH       = 16
) (
    input  logic                clk,
    input  logic                clear_n,
    input  logic                vsync,
    input  logic                enable,
    input  logic [N_TASKS-1:0]  task_mask,
    input  logic [N_TASKS-1:0]  task_done,
    input  logic                clear_err,
`ifdef FRAME_SCHED_DIVIDER_EN
    input  logic [3:0]          frame_div,
`endif
    output logic [N_TASKS-1:0]  task_start,
    output logic                busy,
    output logic [FC_WIDTH-1:0] frame_count,
    output logic [N_TASKS-1:0]  timeout_err,
    output logic                overrun
);

    localparam int IDX_W   = (N_TASKS > 1) ? $clog2(N_TASKS) : 1;
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(N_TASKS - 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        FINISH
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [FC_WIDTH-1:0]  frame_count_q, frame_count_d;
    logic [N_TASKS-1:0]   timeout_err_q, timeout_err_d;
    logic                 overrun_q, overrun_d;
    logic                 vsync_q;   // vsync delayed by one cycle
    logic                 armed_q, armed_d;
`ifdef FRAME_SCHED_DIVIDER_EN
    logic [3:0]           edge_cnt_q, edge_cnt_d;
`endif

    logic                 vsync_edge;
    logic                 launch;
    logic                 advance;
    logic [N_TASKS-1:0]   timeout_set;

    // Rising-edge detect. armed_q stays low until vsync has been seen low
    // after reset, so a vsync already high at release is not an edge.
    assign vsync_edge = vsync & ~vsync_q & armed_q;
    assign armed_d    = armed_q | ~vsync;

    // Next-state logic for the sequencer, counters and sticky error flags.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d       = state_q;
        idx_d         = idx_q;
        timer_d       = timer_q;
        frame_count_d = frame_count_q;
        launch        = 1'b0;
        advance       = 1'b0;
        timeout_set   = '0;
`ifdef FRAME_SCHED_DIVIDER_EN
        edge_cnt_d    = edge_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (vsync_edge && enable) begin
`ifdef FRAME_SCHED_DIVIDER_EN
                    if (edge_cnt_q == frame_div) begin
                        launch     = 1'b1;
                        edge_cnt_d = '0;
                    end else begin
                        edge_cnt_d = edge_cnt_q + 4'd1;
                    end
`else
                    launch = 1'b1;
`endif
                end
                if (launch) begin
                    idx_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (task_mask[idx_q]) begin
                    timer_d = '0;
                    state_d = WAIT;
                end else begin
                    advance = 1'b1;
                end
            end
            WAIT: begin
                if (task_done[idx_q]) begin
                    advance = 1'b1;
                end else if (timer_q == TIMER_MAX) begin
                    timeout_set[idx_q] = 1'b1;
                    advance            = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            FINISH: begin
                frame_count_d = frame_count_q + 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (advance) begin
            if (idx_q == IDX_LAST) begin
                state_d = FINISH;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = ISSUE;
            end
        end

        // Sticky flags: a clear drops old bits, a same-cycle set still lands.
        timeout_err_d = (clear_err ? '0 : timeout_err_q) | timeout_set;
        overrun_d     = (clear_err ? 1'b0 : overrun_q)
                      | (vsync_edge & enable & (state_q != IDLE));
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            timer_q       <= '0;
            frame_count_q <= '0;
            timeout_err_q <= '0;
            overrun_q     <= 1'b0;
            vsync_q       <= 1'b0;
            armed_q       <= 1'b0;
`ifdef FRAME_SCHED_DIVIDER_EN
            edge_cnt_q    <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q       <= state_d;
            idx_q         <= idx_d;
            timer_q       <= timer_d;
            frame_count_q <= frame_count_d;
            timeout_err_q <= timeout_err_d;
            overrun_q     <= overrun_d;
            vsync_q       <= vsync;
            armed_q       <= armed_d;
`ifdef FRAME_SCHED_DIVIDER_EN
            edge_cnt_q    <= edge_cnt_d;
`endif
        end
    end

    // Start pulse is a decode of the registered state: one cycle, one-hot.
    always_comb begin
        task_start = '0;
        if (state_q == ISSUE) begin
            task_start[idx_q] = task_mask[idx_q];
        end
    end

    assign busy        = (state_q != IDLE);
    assign frame_count = frame_count_q;
    assign timeout_err = timeout_err_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Self-checking bench for frame_scheduler. Each frame is predicted by a
// timeline model (task start offsets, finish cycle, sticky flag outcome)
// built from the sequencing rules, then compared with what the DUT does.
`timescale 1ns/1ps
module tb_frame_scheduler;

    localparam int N   = 4;
    localparam int TO  = 16;
    localparam int FCW = 3;
    localparam int NEVER = 999;

    logic           clk = 1'b0;
    logic           clear_n;
    logic           vsync;
    logic           enable;
    logic [N-1:0]   task_mask;
    logic [N-1:0]   task_done;
    logic           clear_err;
`ifdef FRAME_SCHED_DIVIDER_EN
    logic [3:0]     frame_div;
`endif
    logic [N-1:0]   task_start;
    logic           busy;
    logic [FCW-1:0] frame_count;
    logic [N-1:0]   timeout_err;
    logic           overrun;

    int n_cmp = 0;
    int n_bad = 0;

    int         fc_exp  = 0;
    logic [N-1:0] err_exp = '0;
    logic       ovr_exp = 1'b0;
    int         dly [N];

    always #5 clk = ~clk;

    frame_scheduler #(
        .N_TASKS        (N),
        .TIMEOUT_CYCLES (TO),
        .FC_WIDTH       (FCW)
    ) dut (
        .clk         (clk),
        .clear_n     (clear_n),
        .vsync       (vsync),
        .enable      (enable),
        .task_mask   (task_mask),
        .task_done   (task_done),
        .clear_err   (clear_err),
`ifdef FRAME_SCHED_DIVIDER_EN
        .frame_div   (frame_div),
`endif
        .task_start  (task_start),
        .busy        (busy),
        .frame_count (frame_count),
        .timeout_err (timeout_err),
        .overrun     (overrun)
    );

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            vsync     = 1'b0;
            task_done = '0;
            clear_err = 1'b0;
            enable    = 1'b1;
        end
    endtask

    // Launch one frame and compare it against the timeline model.
    // ovr_at: cycle a second vsync rise is driven (-1 none); clr_at: cycle of
    // a clear_err pulse (-1 none); en_low_from: enable dropped from here (-1 none).
    task automatic run_frame(input logic [N-1:0] mask, input int ovr_at,
                             input int clr_at, input int en_low_from,
                             input string name);
        int exp_start [N];
        int exp_set   [N];
        int got_start [N];
        int due       [N];
        int t, fin, idle_rel, extra;
        logic [N-1:0] err_next;
        logic         ovr_next;

        // Timeline model: cycle 0 is the first cycle after the sampling edge.
        t = 0;
        for (int i = 0; i < N; i++) begin
            exp_start[i] = -1;
            exp_set[i]   = -1;
            if (mask[i]) begin
                exp_start[i] = t;
                if (dly[i] >= 1 && dly[i] <= TO) begin
                    t = t + dly[i] + 1;
                end else begin
                    exp_set[i] = t + TO;
                    t = t + TO + 1;
                end
            end else begin
                t = t + 1;
            end
        end
        fin = t;

        err_next = (clr_at >= 0) ? '0 : err_exp;
        for (int i = 0; i < N; i++)
            if (exp_set[i] >= 0 && (clr_at < 0 || exp_set[i] >= clr_at))
                err_next[i] = 1'b1;
        ovr_next = (clr_at >= 0) ? 1'b0 : ovr_exp;
        if (ovr_at >= 0 && ovr_at <= fin &&
            !(en_low_from >= 0 && ovr_at >= en_low_from) &&
            (clr_at < 0 || ovr_at >= clr_at))
            ovr_next = 1'b1;

        // Stimulus and observation.
        idle_cycles(2);
        task_mask = mask;
        for (int i = 0; i < N; i++) begin
            got_start[i] = -1;
            due[i]       = 1 << 20;
        end
        idle_rel = -1;
        extra    = 0;
        @(posedge clk); #1;
        vsync = 1'b1;
        for (int rel = 0; rel < 400; rel++) begin
            @(posedge clk); #1;
            vsync     = (rel < 3) || (ovr_at >= 0 && rel >= ovr_at && rel < ovr_at + 3);
            enable    = !(en_low_from >= 0 && rel >= en_low_from);
            clear_err = (rel == clr_at);
            for (int i = 0; i < N; i++) task_done[i] = (rel >= due[i]);
            @(negedge clk);
            if ($countones(task_start) > 1) extra++;
            for (int i = 0; i < N; i++) begin
                if (task_start[i]) begin
                    if (got_start[i] >= 0) begin
                        extra++;
                    end else begin
                        got_start[i] = rel;
                        due[i]       = rel + dly[i];
                    end
                end
            end
            if (!busy) begin
                idle_rel = rel;
                break;
            end
        end
        vsync     = 1'b0;
        task_done = '0;
        clear_err = 1'b0;
        enable    = 1'b1;

        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (got_start[i] !== exp_start[i]) begin
                n_bad++;
                $display("FAIL %s start[%0d] cycle: got %0d expected %0d",
                         name, i, got_start[i], exp_start[i]);
            end
        end
        n_cmp++;
        if (idle_rel !== fin + 1) begin
            n_bad++;
            $display("FAIL %s busy-low cycle: got %0d expected %0d", name, idle_rel, fin + 1);
        end
        n_cmp++;
        if (extra !== 0) begin
            n_bad++;
            $display("FAIL %s extra start pulses: got %0d expected 0", name, extra);
        end

        fc_exp  = (fc_exp + 1) % (1 << FCW);
        err_exp = err_next;
        ovr_exp = ovr_next;

        n_cmp++;
        if (frame_count !== FCW'(fc_exp)) begin
            n_bad++;
            $display("FAIL %s frame_count: got %0d expected %0d", name, frame_count, fc_exp);
        end
        n_cmp++;
        if (timeout_err !== err_exp) begin
            n_bad++;
            $display("FAIL %s timeout_err: got %b expected %b", name, timeout_err, err_exp);
        end
        n_cmp++;
        if (overrun !== ovr_exp) begin
            n_bad++;
            $display("FAIL %s overrun: got %b expected %b", name, overrun, ovr_exp);
        end
    endtask

    task automatic set_dly(input int d0, input int d1, input int d2, input int d3);
        dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
    endtask

    task automatic test_reset();
        int viol;
        clear_n = 1'b1;
        #1 clear_n = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            vsync = ~vsync;
            @(negedge clk);
            n_cmp++;
            if ({task_start, busy, frame_count, timeout_err, overrun} !== '0) begin
                n_bad++;
                $display("FAIL reset outputs: got %b expected all zero",
                         {task_start, busy, frame_count, timeout_err, overrun});
            end
        end
        // Release with vsync already high: no sequence may start.
        vsync = 1'b1;
        @(negedge clk);
        clear_n = 1'b1;
        viol = 0;
        repeat (6) begin
            @(posedge clk); #1;
            vsync = 1'b1;
            @(negedge clk);
            if (busy || task_start != '0) viol++;
        end
        n_cmp++;
        if (viol !== 0) begin
            n_bad++;
            $display("FAIL reset release with vsync high: got %0d busy cycles expected 0", viol);
        end
        idle_cycles(2);
    endtask

    task automatic test_basic();
        set_dly(3, 3, 3, 3);
        run_frame(4'b1111, -1, -1, -1, "basic");
    endtask

    task automatic test_mask();
        set_dly(3, 3, 3, 3);
        run_frame(4'b0101, -1, -1, -1, "mask");
        run_frame(4'b0000, -1, -1, -1, "all_masked");
    endtask

    task automatic test_timeout();
        set_dly(3, NEVER, 3, 3);
        run_frame(4'b1111, -1, -1, -1, "timeout");
    endtask

    task automatic test_clear_err();
        idle_cycles(1);
        @(posedge clk); #1;
        clear_err = 1'b1;
        @(posedge clk); #1;
        clear_err = 1'b0;
        @(negedge clk);
        err_exp = '0;
        ovr_exp = 1'b0;
        n_cmp++;
        if (timeout_err !== err_exp) begin
            n_bad++;
            $display("FAIL clear_err timeout_err: got %b expected %b", timeout_err, err_exp);
        end
    endtask

    task automatic test_done_boundary();
        // Done in the last WAIT cycle wins; one cycle later is a timeout.
        set_dly(TO, TO + 1, 1, TO);
        run_frame(4'b1111, -1, -1, -1, "done_boundary");
    endtask

    task automatic test_overrun();
        set_dly(3, 3, 3, 3);
        run_frame(4'b1111, 6, -1, -1, "overrun");
    endtask

    task automatic test_set_wins();
        // Task 2 issues at cycle 8 and times out in cycle 8+TO; clear there.
        set_dly(3, 3, NEVER, 3);
        run_frame(4'b1111, -1, 8 + TO, -1, "set_wins");
    endtask

    task automatic test_enable();
        int viol;
        idle_cycles(2);
        enable = 1'b0;
        @(posedge clk); #1;
        enable = 1'b0;
        vsync  = 1'b1;
        viol = 0;
        repeat (4) begin
            @(posedge clk); #1;
            enable = 1'b0;
            @(negedge clk);
            if (busy) viol++;
        end
        n_cmp++;
        if (viol !== 0) begin
            n_bad++;
            $display("FAIL enable-low edge: got %0d busy cycles expected 0", viol);
        end
        idle_cycles(2);
        set_dly(3, 3, 3, 3);
        run_frame(4'b1111, 6, -1, 2, "enable_drop");
    endtask

    task automatic test_random();
        logic [N-1:0] m;
        int ov, cl;
        for (int f = 0; f < 14; f++) begin
            m = N'($urandom);
            for (int i = 0; i < N; i++)
                dly[i] = ($urandom_range(0, 4) == 0) ? NEVER : int'($urandom_range(1, TO));
            ov = ($urandom_range(0, 2) == 0) ? 4 : -1;
            cl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_frame(m, ov, cl, -1, "random");
        end
    endtask

    task automatic test_async_reset();
        logic was_busy;
        idle_cycles(2);
        task_mask = '1;
        task_done = '0;
        @(posedge clk); #1;
        vsync = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
        end
        vsync = 1'b0;
        was_busy = busy;
        n_cmp++;
        if (was_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL async_reset busy before reset: got %b expected 1", was_busy);
        end
        #2 clear_n = 1'b0;
        #1;
        fc_exp  = 0;
        err_exp = '0;
        ovr_exp = 1'b0;
        n_cmp++;
        if ({task_start, busy, frame_count, timeout_err, overrun} !== '0) begin
            n_bad++;
            $display("FAIL async_reset outputs: got %b expected all zero",
                     {task_start, busy, frame_count, timeout_err, overrun});
        end
        @(negedge clk);
        clear_n = 1'b1;
        idle_cycles(3);
        set_dly(2, 2, 2, 2);
        run_frame(4'b0011, -1, -1, -1, "after_reset");
    endtask

`ifdef FRAME_SCHED_DIVIDER_EN
    task automatic test_divider();
        logic launched, exp_launch;
        frame_div = 4'd2;
        task_mask = '0;
        for (int e = 1; e <= 9; e++) begin
            idle_cycles(3);
            @(posedge clk); #1;
            vsync = 1'b1;
            @(posedge clk); #1;
            @(negedge clk);
            launched   = busy;
            exp_launch = (e % 3 == 0);
            n_cmp++;
            if (launched !== exp_launch) begin
                n_bad++;
                $display("FAIL divider edge %0d launch: got %b expected %b", e, launched, exp_launch);
            end
            if (exp_launch) fc_exp = (fc_exp + 1) % (1 << FCW);
            idle_cycles(8);
        end
        n_cmp++;
        if (frame_count !== FCW'(fc_exp)) begin
            n_bad++;
            $display("FAIL divider frame_count: got %0d expected %0d", frame_count, fc_exp);
        end
        frame_div = 4'd0;
    endtask
`endif

    initial begin
        vsync     = 1'b0;
        enable    = 1'b1;
        task_mask = '0;
        task_done = '0;
        clear_err = 1'b0;
`ifdef FRAME_SCHED_DIVIDER_EN
        frame_div = 4'd0;
`endif
        test_reset();
        test_basic();
        test_mask();
        test_timeout();
        test_clear_err();
        test_done_boundary();
        test_overrun();
        test_set_wins();
        test_enable();
        test_random();
        test_async_reset();
`ifdef FRAME_SCHED_DIVIDER_EN
        test_divider();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
